// File: rtl/sum_bcd_display_if.sv
// Operand/handshake and display bundle shared by the reading stage and the BCD display block.
// The master drives the operands and Sum_ready; the slave drives the display and status lines.
interface sum_bcd_display_if;
  logic [9:0] Num1_value;
  logic [9:0] Num2_value;
  logic       Sum_ready;
  logic [6:0] Seg;
  logic [3:0] Anodo;
  logic       Busy;
  logic       Sum_valid;

  modport master (
    output Num1_value, Num2_value, Sum_ready,
    input  Seg, Anodo, Busy, Sum_valid
  );

  modport slave (
    input  Num1_value, Num2_value, Sum_ready,
    output Seg, Anodo, Busy, Sum_valid
  );
endinterface

// File: rtl/sum_bcd_display.sv
// Adds two 10-bit operands, converts the sum to BCD with a one-bit-per-clock double-dabble,
// and drives a 4-digit multiplexed 7-segment display with leading-zero blanking.
module sum_bcd_display #(
  parameter int REFRESH_DIV    = 6750,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  sum_bcd_display_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int         CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_INV  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

  logic [1:0]    state_reg;
  logic          ready_prev_reg;
  logic          pending_reg;
  logic [10:0]   bin_reg;
  logic [15:0]   bcd_reg;
  logic [3:0]    iter_reg;
  logic [15:0]   disp_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [6:0]    seg_reg;
  logic [3:0]    an_reg;

  logic          start;
  logic          launch;
  logic [15:0]   bcd_adj;
  logic [15:0]   bcd_shift;
  logic [10:0]   bin_shift;
  logic [10:0]   sum;

  assign start  = bus.Sum_ready && !ready_prev_reg;
  assign launch = start || pending_reg;
  assign sum    = {1'b0, bus.Num1_value} + {1'b0, bus.Num2_value};

  // Add-3 correction on every nibble before the shift.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign bcd_shift = {bcd_adj[14:0], bin_reg[10]};
  assign bin_shift = {bin_reg[9:0], 1'b0};

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_reg      <= ST_IDLE;
      ready_prev_reg <= 1'b0;
      pending_reg    <= 1'b0;
      bin_reg        <= '0;
      bcd_reg        <= '0;
      iter_reg       <= '0;
      disp_reg       <= '0;
    end else begin
      ready_prev_reg <= bus.Sum_ready;
      case (state_reg)
        ST_IDLE: begin
          if (launch) begin
            bin_reg     <= sum;
            bcd_reg     <= '0;
            iter_reg    <= '0;
            pending_reg <= 1'b0;
            state_reg   <= ST_CONV;
          end
        end
        ST_CONV: begin
          bin_reg <= bin_shift;
          bcd_reg <= bcd_shift;
          if (iter_reg == 4'd10) begin
            disp_reg  <= bcd_shift;
            state_reg <= ST_DONE;
          end else begin
            iter_reg <= iter_reg + 4'd1;
          end
        end
        ST_DONE: begin
          // An edge seen here is remembered and launched from the next IDLE cycle.
          if (start) pending_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  logic          wrap;
  logic [1:0]    idx_next;
  logic [3:0]    digit;
  logic [3:0]    blank;
  logic [6:0]    glyph;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;

  assign wrap     = (cnt_reg == CNT_MAX);
  assign idx_next = wrap ? idx_reg + 2'd1 : idx_reg;
  assign digit    = disp_reg[4*idx_next +: 4];

  assign blank[3] = (disp_reg[15:12] == 4'd0);
  assign blank[2] = blank[3] && (disp_reg[11:8] == 4'd0);
  assign blank[1] = blank[2] && (disp_reg[7:4] == 4'd0);
  assign blank[0] = 1'b0;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    glyph = 7'b0000000;
    case (digit)
      4'd0: glyph = 7'b0111111;
      4'd1: glyph = 7'b0000110;
      4'd2: glyph = 7'b1011011;
      4'd3: glyph = 7'b1001111;
      4'd4: glyph = 7'b1100110;
      4'd5: glyph = 7'b1101101;
      4'd6: glyph = 7'b1111101;
      4'd7: glyph = 7'b0000111;
      4'd8: glyph = 7'b1111111;
      4'd9: glyph = 7'b1101111;
      default: glyph = 7'b0000000;
    endcase
  end

  assign seg_next = (blank[idx_next] ? 7'b0000000 : glyph) ^ SEG_INV;
  assign an_next  = (4'b0001 << idx_next) ^ AN_INV;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      cnt_reg <= '0;
      idx_reg <= 2'd0;
      seg_reg <= 7'b0111111 ^ SEG_INV;
      an_reg  <= 4'b0001 ^ AN_INV;
    end else begin
      cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
      idx_reg <= idx_next;
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign bus.Seg       = seg_reg;
  assign bus.Anodo     = an_reg;
  assign bus.Busy      = (state_reg == ST_CONV);
  assign bus.Sum_valid = (state_reg == ST_DONE);

endmodule

// File: doc/sum_bcd_display.md
Name: sum_bcd_display

Overview:
- Downstream consumer of the keypad reading stage (mod_lecturaTeclado); receives Num1_value, Num2_value and Sum_ready.
- Adds the two operands and converts the binary sum to 4 BCD digits with a sequential double-dabble (one iteration per clock).
- Drives a 4-digit multiplexed 7-segment display with leading-zero blanking.
- Instantiated in top_teclado alongside the keypad scanner and the reading stage.

Parameters:
- REFRESH_DIV, 6750: clocks per digit slot (27 MHz / 6750 = 4 kHz slot rate, 1 kHz per digit); must be ≥ 2.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when its bit is 0.
- AN_ACTIVE_LOW, 1: 1 = digit enabled when its bit is 0.

Ports:
- Clock  in  1  system clock, 27 MHz.
- Reset_n  in  1  synchronous, active-low reset.
- Num1_value  in  10  first operand, unsigned binary.
- Num2_value  in  10  second operand, unsigned binary.
- Sum_ready  in  1  level from the reading stage; only its rising edge starts a conversion.
- Seg  out  7  segments {g,f,e,d,c,b,a}, registered.
- Anodo  out  4  digit enables, one-hot, registered; bit 0 = units digit.
- Busy  out  1  high while a conversion is in progress.
- Sum_valid  out  1  one-cycle pulse when new BCD digits are latched.

Behaviour:
- One clock domain. Reset_n is synchronous and active-low. All state is updated on the rising edge of Clock.
- Reset values:
  - FSM = IDLE; Busy = 0; Sum_valid = 0.
  - Display BCD register = 0; digit index = 0; refresh counter = 0.
  - Anodo = digit 0 enabled (4'b1110 when AN_ACTIVE_LOW=1).
  - Seg = glyph "0" (7'b1000000 when SEG_ACTIVE_LOW=1).
- Edge detect: a one-cycle register holds the previous Sum_ready. A start occurs at edge k when Sum_ready is 1 and the registered previous value is 0.
- FSM IDLE:
  - On a start at edge k: capture sum = Num1_value + Num2_value (11-bit, maximum 2046) into the shift register, clear the 16-bit BCD scratch, set iteration counter = 0, go to CONV.
  - Busy = 1 from after edge k.
- FSM CONV:
  - Each edge: every BCD nibble ≥ 5 gets +3, then {bcd, bin} shifts left by 1.
  - 11 iterations occur at edges k+1..k+11.
  - At edge k+11: latch the scratch into the display BCD register, go to DONE.
- FSM DONE:
  - Sum_valid = 1 and Busy = 0 for exactly one cycle (after edge k+11).
  - Unconditional return to IDLE at edge k+12.
  - A rising edge of Sum_ready that coincides with DONE is honoured. The edge register keeps running at all times, so the sampled edge is acted on in the following IDLE cycle.
- Rising edges of Sum_ready during CONV are ignored (no queueing). A level held high produces exactly one conversion.
- The display BCD register changes only at the CONV→DONE transition. The display keeps showing the old value throughout a conversion.
- Refresh:
  - Counter runs 0..REFRESH_DIV-1 continuously, including during conversion.
  - On wrap, the digit index advances 0→1→2→3→0.
  - Anodo/Seg register the new index's enable and glyph on the same edge as the wrap.
- Leading-zero blanking:
  - d3 is blank if d3 = 0.
  - d2 is blank if d3 = d2 = 0.
  - d1 is blank if d3 = d2 = d1 = 0.
  - d0 is never blank.
  - A blank digit drives all segments off; its anode stays enabled.
- Glyphs: 0–9 only. Nibble values 10–15 cannot occur; if one does, all segments are off.
- SEG_ACTIVE_LOW / AN_ACTIVE_LOW invert the respective outputs as a whole.
- Reset asserted mid-conversion: abort, return to the reset values above, and discard the pending sum.

Test Plan:
- Reset held 3 cycles, then released, REFRESH_DIV=4: Anodo steps 1110→1101→1011→0111→1110 every 4 cycles; Seg = 1000000 (glyph "0") on digit 0 and 1111111 (blank) on digits 1–3.
- Num1=123, Num2=456, Sum_ready rises at edge k: Busy high k+1..k+11; Sum_valid pulse after edge k+11; digits d3..d0 = blank,5,7,9.
- Num1=999, Num2=999: digits 1,9,9,8. Num1=1023, Num2=1023: digits 2,0,4,6. Num1=0, Num2=0: blank,blank,blank,0.
- Sum_ready pulses again at k+5 with new operands: ignored; only one Sum_valid pulse, display shows the first sum. Sum_ready held high for 50 cycles: exactly one Sum_valid.
- Display at 579; start 100+5, then Reset_n low at k+6: Busy=0, no Sum_valid, display shows "0" with blanked leading digits. Rerun 100+5: digits blank,1,0,5 (the inner zero is not blanked).
